// File: rtl/key_event.sv
// Key event decoder: turns a debounced key level into one-cycle short / double / long / repeat flags.
// Latency: key_pressed and all flags are registered (one cycle after the deciding sample).
// No backpressure: flags are fire-and-forget pulses, at most one asserted in any cycle.
module key_event #(
  parameter bit KEY_ACTIVE_LOW = 1'b1,
  parameter int LONG_CYCLES    = 50_000_000,
  parameter int DCLICK_CYCLES  = 15_000_000,
  parameter int REPEAT_CYCLES  = 10_000_000,
  parameter int CNT_W          = 26
) (
  input  logic clk,
  input  logic rst,
  input  logic key_filter,
  output logic key_pressed,
  output logic short_flag,
  output logic double_flag,
  output logic long_flag,
  output logic repeat_flag
);

  typedef enum logic [2:0] {
    ARM    = 3'd0,
    IDLE   = 3'd1,
    PRESS1 = 3'd2,
    WAIT2  = 3'd3,
    PRESS2 = 3'd4,
    LONG   = 3'd5
  } state_t;

  localparam logic [CNT_W-1:0] LONG_LAST   = CNT_W'(LONG_CYCLES - 1);
  localparam logic [CNT_W-1:0] DCLICK_LAST = CNT_W'(DCLICK_CYCLES - 1);
  localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             act_q;
  logic             key_pressed_q;
  logic             short_q, short_d;
  logic             double_q, double_d;
  logic             long_q, long_d;
  logic             repeat_q, repeat_d;

  // Normalised level: 1 means pressed regardless of key polarity.
  logic act;
  logic press_edge;
  assign act        = key_filter ^ KEY_ACTIVE_LOW;
  assign press_edge = act & ~act_q;

  assign key_pressed = key_pressed_q;
  assign short_flag  = short_q;
  assign double_flag = double_q;
  assign long_flag   = long_q;
  assign repeat_flag = repeat_q;

  // State, counter, previous sample and registered flags.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= ARM;
      cnt_q         <= '0;
      act_q         <= 1'b0;
      key_pressed_q <= 1'b0;
      short_q       <= 1'b0;
      double_q      <= 1'b0;
      long_q        <= 1'b0;
      repeat_q      <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      act_q         <= act;
      key_pressed_q <= act;
      short_q       <= short_d;
      double_q      <= double_d;
      long_q        <= long_d;
      repeat_q      <= repeat_d;
    end
  end

  // Next-state, counter and flag decisions; every state change clears the counter.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    short_d  = 1'b0;
    double_d = 1'b0;
    long_d   = 1'b0;
    repeat_d = 1'b0;
    case (state_q)
      // The filter resets to 0, which reads as pressed for active-low keys:
      // wait for a genuine released level before accepting presses.
      ARM: begin
        if (!act) begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      end
      IDLE: begin
        if (press_edge) begin
          state_d = PRESS1;
          cnt_d   = '0;
        end
      end
      // Release wins over the long threshold when both occur on the same edge.
      PRESS1: begin
        if (!act) begin
          state_d = WAIT2;
          cnt_d   = '0;
        end else if (cnt_q == LONG_LAST) begin
          long_d  = 1'b1;
          state_d = LONG;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      // A second press wins over window expiry on the same edge.
      WAIT2: begin
        if (press_edge) begin
          double_d = 1'b1;
          state_d  = PRESS2;
          cnt_d    = '0;
        end else if (cnt_q == DCLICK_LAST) begin
          short_d = 1'b1;
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      // Second press of a double click: no long detection, just wait for release.
      PRESS2: begin
        if (!act) begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      end
      LONG: begin
        if (!act) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == REPEAT_LAST) begin
          repeat_d = 1'b1;
          cnt_d    = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d = ARM;
        cnt_d   = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_key_event.sv
// Randomised + directed bench for key_event with a timestamp-based reference model.
// Expected flags are queued with the edge number they must appear on; a monitor pops them.
// Flags have no backpressure; the monitor samples 1 time unit after every rising edge.
module tb_key_event;

  localparam int L = 100;
  localparam int D = 40;
  localparam int R = 20;

  localparam int C_SHORT  = 1;
  localparam int C_DOUBLE = 2;
  localparam int C_LONG   = 3;
  localparam int C_REPEAT = 4;

  logic clk = 1'b0;
  logic rst;
  logic key_filter;
  logic key_pressed, short_flag, double_flag, long_flag, repeat_flag;

  key_event #(
    .KEY_ACTIVE_LOW(1'b1),
    .LONG_CYCLES(L),
    .DCLICK_CYCLES(D),
    .REPEAT_CYCLES(R),
    .CNT_W(8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .key_filter(key_filter),
    .key_pressed(key_pressed),
    .short_flag(short_flag),
    .double_flag(double_flag),
    .long_flag(long_flag),
    .repeat_flag(repeat_flag)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int code;
    int edge_n;
  } exp_t;
  exp_t q[$];

  int errors = 0;
  int checks = 0;
  int seen[5];

  // Reference model: tracks what the key is doing and when it started, and
  // derives every flag from elapsed edge counts since those timestamps.
  // phase: 0 waiting for first release, 1 idle, 2 first press held,
  //        3 gap after short press, 4 second press held, 5 held past long.
  int phase;
  int t_press;
  int t_release;
  bit prev_act;
  bit kp_exp;

  function automatic void push(int code, int e);
    exp_t x;
    x.code   = code;
    x.edge_n = e;
    q.push_back(x);
  endfunction

  function automatic void model_reset();
    phase    = 0;
    prev_act = 1'b0;
    kp_exp   = 1'b0;
    q.delete();
  endfunction

  // Predicts the effect of the coming rising edge given the level sampled there.
  function automatic void model_edge(bit act);
    int  e;
    bit  pe;
    e  = cyc + 1;
    pe = act && !prev_act;
    case (phase)
      0: if (!act) phase = 1;
      1: if (pe) begin phase = 2; t_press = e; end
      2: begin
        if (!act) begin
          phase = 3; t_release = e;
        end else if (e - t_press == L) begin
          push(C_LONG, e); phase = 5;
        end
      end
      3: begin
        if (pe) begin
          push(C_DOUBLE, e); phase = 4;
        end else if (e - t_release == D) begin
          push(C_SHORT, e); phase = 1;
        end
      end
      4: if (!act) phase = 1;
      5: begin
        if (!act) phase = 1;
        else if ((e - t_press - L) % R == 0) push(C_REPEAT, e);
      end
      default: phase = 0;
    endcase
    prev_act = act;
    kp_exp   = act;
  endfunction

  // Drive a key level for n cycles; called and returns at a falling edge.
  task automatic drive(input bit kf, input int n);
    for (int i = 0; i < n; i++) begin
      key_filter = kf;
      model_edge(!kf);
      @(negedge clk);
    end
  endtask

  task automatic do_reset(input int n);
    rst = 1'b0;
    model_reset();
    #1;
    checks++;
    if ({key_pressed, short_flag, double_flag, long_flag, repeat_flag} !== 5'b0) begin
      errors++;
      $display("FAIL async_reset_outputs: got %b, need 00000",
               {key_pressed, short_flag, double_flag, long_flag, repeat_flag});
    end
    repeat (n) @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic check_counts(input string name, input int s0[5], input int es, input int ed,
                              input int el, input int er);
    checks++;
    if (seen[1] - s0[1] != es || seen[2] - s0[2] != ed ||
        seen[3] - s0[3] != el || seen[4] - s0[4] != er) begin
      errors++;
      $display("FAIL %s counts: got s=%0d d=%0d l=%0d r=%0d, need s=%0d d=%0d l=%0d r=%0d", name,
               seen[1] - s0[1], seen[2] - s0[2], seen[3] - s0[3], seen[4] - s0[4], es, ed, el, er);
    end
  endtask

  // Monitor: compares key_pressed every cycle and pops one expectation per flag pulse.
  initial begin
    logic [3:0] fl;
    int code;
    exp_t x;
    forever begin
      @(posedge clk);
      #1;
      checks++;
      if (key_pressed !== kp_exp) begin
        errors++;
        $display("FAIL key_pressed @%0d: got %b, need %b", cyc, key_pressed, kp_exp);
      end
      fl = {repeat_flag, long_flag, double_flag, short_flag};
      if (fl != 4'b0) begin
        case (fl)
          4'b0001: code = C_SHORT;
          4'b0010: code = C_DOUBLE;
          4'b0100: code = C_LONG;
          4'b1000: code = C_REPEAT;
          default: code = 0;
        endcase
        if (code != 0) seen[code]++;
        checks++;
        if (q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_flag @%0d: got flags %b, need none", cyc, fl);
        end else begin
          x = q.pop_front();
          if (x.code != code || x.edge_n != cyc) begin
            errors++;
            $display("FAIL flag_match: got code %0d @%0d (flags %b), need code %0d @%0d",
                     code, cyc, fl, x.code, x.edge_n);
          end
        end
      end else if (q.size() > 0 && q[0].edge_n <= cyc) begin
        x = q.pop_front();
        checks++;
        errors++;
        $display("FAIL missed_flag: got none @%0d, need code %0d @%0d", cyc, x.code, x.edge_n);
      end
    end
  end

  initial begin
    int s0[5];
    rst        = 1'b0;
    key_filter = 1'b0;
    model_reset();
    #2;
    checks++;
    if ({key_pressed, short_flag, double_flag, long_flag, repeat_flag} !== 5'b0) begin
      errors++;
      $display("FAIL reset_state: got %b, need 00000",
               {key_pressed, short_flag, double_flag, long_flag, repeat_flag});
    end
    repeat (3) @(negedge clk);
    rst = 1'b1;

    // Filter output reads as pressed after reset: must be ignored until released.
    s0 = seen;
    drive(1'b0, 200);
    drive(1'b1, 50);
    check_counts("arm_hold", s0, 0, 0, 0, 0);

    s0 = seen;
    drive(1'b0, 10);
    drive(1'b1, 60);
    check_counts("short_press", s0, 1, 0, 0, 0);

    s0 = seen;
    drive(1'b0, 10);
    drive(1'b1, 15);
    drive(1'b0, 10);
    drive(1'b1, 200);
    check_counts("double_click", s0, 0, 1, 0, 0);

    s0 = seen;
    drive(1'b0, 165);
    drive(1'b1, 60);
    check_counts("long_repeat", s0, 0, 0, 1, 3);

    s0 = seen;
    drive(1'b0, 100);
    drive(1'b1, 60);
    check_counts("boundary_release_wins", s0, 1, 0, 0, 0);

    s0 = seen;
    drive(1'b0, 101);
    drive(1'b1, 60);
    check_counts("boundary_long", s0, 0, 0, 1, 0);

    // Reset while in LONG, key still held afterwards: that press must be ignored.
    s0 = seen;
    drive(1'b0, 130);
    do_reset(5);
    drive(1'b0, 50);
    drive(1'b1, 60);
    check_counts("reset_in_long", s0, 0, 0, 1, 1);

    // Reset while waiting for a double click: pending short press is dropped.
    s0 = seen;
    drive(1'b0, 10);
    drive(1'b1, 20);
    do_reset(5);
    drive(1'b1, 80);
    check_counts("reset_in_wait2", s0, 0, 0, 0, 0);

    for (int i = 0; i < 60; i++) begin
      drive(1'b0, $urandom_range(1, 150));
      drive(1'b1, $urandom_range(1, 70));
      if ($urandom_range(0, 15) == 0) do_reset($urandom_range(1, 4));
    end
    drive(1'b1, 100);

    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expectations, need 0", q.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/key_event.md
Name: key_event

Overview:
- Downstream consumer of the debounced key level produced by the key debounce filter.
- Turns the stable key level into one-cycle event flags: short press, double click, long press, and auto-repeat while the key is held.
- Flags feed the control logic (mode/counter/LED state machines) directly. No further synchronisation is needed; the input is already synchronous to clk.

Parameters:
- KEY_ACTIVE_LOW, 1, 1: key pressed when key_filter==0; 0: pressed when key_filter==1.
- LONG_CYCLES, 50_000_000, hold time (clk cycles) to qualify a long press (1 s at 50 MHz). Must be >=2.
- DCLICK_CYCLES, 15_000_000, window after a short release in which a second press counts as a double click. Must be >=2.
- REPEAT_CYCLES, 10_000_000, period of repeat_flag while held after long press. Must be >=2.
- CNT_W, 26, counter width. Must hold max(LONG_CYCLES, DCLICK_CYCLES, REPEAT_CYCLES)-1.

Ports:
- clk, input, 1, system clock.
- rst, input, 1, asynchronous, active-low reset.
- key_filter, input, 1, debounced key level from the debounce stage.
- key_pressed, output, 1, registered pressed level (polarity-normalised, 1=pressed).
- short_flag, output, 1, one-cycle pulse: single short press confirmed.
- double_flag, output, 1, one-cycle pulse: double click.
- long_flag, output, 1, one-cycle pulse: long press threshold reached.
- repeat_flag, output, 1, one-cycle pulse: auto-repeat tick.

Behaviour:
- Reset values:
  - All outputs 0.
  - State ARM, counter 0.
  - act_d (previous normalised sample) 0.
- act = key_filter XOR KEY_ACTIVE_LOW, giving 1=pressed. The act_d register holds act from the previous cycle.
- Edge definitions:
  - press_edge = act & ~act_d.
  - release_edge = ~act & act_d.
- key_pressed <= act every cycle; one cycle of latency.
- Flags are registered and high for exactly one cycle. At most one flag is asserted in any cycle.
- FSM (evaluated at each rising clk edge):
  - ARM: stays until act==0, then goes to IDLE. This prevents a false press, because the upstream filter resets its output to 0, which reads as pressed for active-low keys.
  - IDLE: on press_edge, go to PRESS1 with cnt<=0.
  - PRESS1:
    - If act==0: go to WAIT2, cnt<=0. Release has priority over the threshold.
    - Else if cnt==LONG_CYCLES-1: long_flag<=1, go to LONG, cnt<=0.
    - Else cnt<=cnt+1.
  - WAIT2:
    - If press_edge: double_flag<=1, go to PRESS2.
    - Else if cnt==DCLICK_CYCLES-1: short_flag<=1, go to IDLE.
    - Else cnt<=cnt+1.
    - Press has priority over window expiry.
  - PRESS2: on act==0, go to IDLE. No long detection on the second press.
  - LONG:
    - If act==0: go to IDLE, no flag.
    - Else if cnt==REPEAT_CYCLES-1: repeat_flag<=1, cnt<=0.
    - Else cnt<=cnt+1.
- Timing, with E0 = the edge at which press_edge is sampled:
  - long_flag is registered at edge E0+LONG_CYCLES.
  - The first repeat_flag is at E0+LONG_CYCLES+REPEAT_CYCLES, then every REPEAT_CYCLES.
- Short press latency: short_flag is registered DCLICK_CYCLES edges after the edge at which the FSM enters WAIT2.
- Counter never wraps. It is cleared on every state change and holds its value in ARM, IDLE and PRESS2.
- Asynchronous reset mid-operation clears everything and returns to ARM. No pending short press is emitted.
- Illegal or unused state encodings go to ARM.

Test Plan (LONG_CYCLES=100, DCLICK_CYCLES=40, REPEAT_CYCLES=20, KEY_ACTIVE_LOW=1):
- Hold key_filter=0 through reset release for 200 cycles, then drive 1 for 50 -> all flags 0, key_pressed=1 during the 0 phase, FSM reaches IDLE.
- From IDLE, drive 0 for 10 cycles then 1 -> short_flag single pulse exactly 40 edges after WAIT2 entry; double_flag, long_flag and repeat_flag stay 0.
- Drive 0 for 10, 1 for 15, 0 for 10, then 1 -> double_flag single pulse one cycle after the second press edge; no short_flag within 200 cycles.
- Hold 0 for 165 cycles -> long_flag at E0+100, repeat_flag at E0+120, +140, +160 (three pulses); release produces no further flags.
- Boundary: release such that act==0 is sampled at the edge where cnt==99 -> short path (WAIT2), no long_flag. Release one cycle later -> long_flag and no short_flag.
- Assert rst low during LONG and during WAIT2 -> all outputs 0 immediately; no short_flag after rst rises; a new press is ignored until a release is seen.
